mdu_hilo: RTL and testbench

- Multi-cycle multiply/divide unit that owns the architectural HI/LO register pair.
- It is the consumer/writer side of the {HI,LO} result pair: the single-cycle datapath issues MULT/MULTU/DIV/DIVU/MTHI/MTLO here and reads HI/LO back for MFHI/MFLO.
- It replaces the combinational X*Y and X/Y paths with a 32-iteration shift engine.
- The pipeline stalls on busy.

---
 rtl/mdu_pkg.sv | 21 ++
 rtl/mdu_iter_core.sv | 59 +++++
 rtl/mdu_hilo.sv | 162 ++++++++++++++++
 tb/tb_mdu_hilo.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared op codes, FSM encoding and iteration count for the HI/LO multiply/divide unit.
// No logic; constants and types only.
// Imported by mdu_hilo and mdu_iter_core.
package mdu_pkg;

    localparam int ITER = 32;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_e;

endpackage

// File: rtl/mdu_iter_core.sv
// One shift-add (multiply) or restoring shift-subtract (divide) step per enabled cycle on magnitudes.
// Latency: one iteration per step pulse; load takes effect on the next edge.
// No backpressure: the caller sequences load/step.
module mdu_iter_core
    import mdu_pkg::*;
#(
    parameter int WIDTH = ITER
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic                 is_div,
    input  logic [WIDTH-1:0]     init_lo,
    input  logic [WIDTH-1:0]     operand,
    output logic [2*WIDTH-1:0]   acc
);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH-1:0]   diff;
    logic               ge;

    always_comb begin
        sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
        ge     = (rem_sh >= {1'b0, opnd_q});
        // The partial remainder stays below the divisor, so the difference fits in WIDTH bits.
        diff   = rem_sh[WIDTH-1:0] - opnd_q;

        acc_d  = acc_q;
        opnd_d = opnd_q;
        if (load) begin
            acc_d  = {{WIDTH{1'b0}}, init_lo};
            opnd_d = operand;
        end else if (step) begin
            if (is_div) begin
                acc_d = {(ge ? diff : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], ge};
            end else begin
                acc_d = {sum, acc_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            opnd_q <= '0;
        end else begin
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/mdu_hilo.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine owning HI/LO; MTHI/MTLO write in one cycle.
// Latency: 33 busy cycles then a one-cycle done pulse with HI/LO updated.
// start is ignored while busy; the issuing pipeline stalls on busy.
module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int WIDTH = ITER,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               done_q, done_d;
    logic               dz_q, dz_d;
    logic               is_div_q, is_div_d;
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
    logic               yz_q, yz_d;

    logic               load, step;
    logic               sgn_op, div_op, sx, sy;
    logic [WIDTH-1:0]   abs_x, abs_y, init_lo, operand;
    logic [WIDTH-1:0]   rem, quo;
    logic [2*WIDTH-1:0] acc, prod;

    mdu_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .step    (step),
        .is_div  (is_div_q),
        .init_lo (init_lo),
        .operand (operand),
        .acc     (acc)
    );

    always_comb begin
        sgn_op  = (op == OP_MULT) || (op == OP_DIV);
        div_op  = (op == OP_DIV) || (op == OP_DIVU);
        sx      = sgn_op & x[WIDTH-1];
        sy      = sgn_op & y[WIDTH-1];
        abs_x   = sx ? -x : x;
        abs_y   = sy ? -y : y;
        // Multiply shifts the multiplier out of the low half; divide shifts the dividend out.
        init_lo = div_op ? abs_x : abs_y;
        operand = div_op ? abs_y : abs_x;
        rem     = acc[2*WIDTH-1:WIDTH];
        quo     = acc[WIDTH-1:0];
        prod    = qneg_q ? -acc : acc;

        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dz_d     = dz_q;
        is_div_d = is_div_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        yz_d     = yz_q;
        load     = 1'b0;
        step     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_MTHI: begin
                            hi_d   = x;
                            done_d = 1'b1;
                        end
                        OP_MTLO: begin
                            lo_d   = x;
                            done_d = 1'b1;
                        end
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            load     = 1'b1;
                            cnt_d    = '0;
                            dz_d     = 1'b0;
                            is_div_d = div_op;
                            qneg_d   = sx ^ sy;
                            rneg_d   = sx;
                            yz_d     = div_op && (y == '0);
                            state_d  = CALC;
                        end
                        default: ;
                    endcase
                end
            end
            CALC: begin
                step  = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (is_div_q) begin
                    // A zero divisor leaves the dividend magnitude as remainder, so hi still comes back as x.
                    hi_d = rneg_q ? -rem : rem;
                    lo_d = yz_q ? '1 : (qneg_q ? -quo : quo);
                    dz_d = yz_q;
                end else begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
                cnt_d   = '0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
            is_div_q <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            yz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
            is_div_q <= is_div_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            yz_q     <= yz_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign div_by_zero = dz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed plus small random stimulus for mdu_hilo with a queue-based scoreboard of HI/LO results.
module tb_mdu_hilo;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] x, y;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t        scb[$];
    logic [31:0] mdl_hi, mdl_lo;
    logic        mdl_dz;
    int          checks = 0;
    int          errors = 0;

    mdu_hilo #(.WIDTH(32), .CNT_W(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .x           (x),
        .y           (y),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] h, input logic [31:0] l, input logic dz);
        exp_t e;
        e.hi = h;
        e.lo = l;
        e.dz = dz;
        scb.push_back(e);
        mdl_hi = h;
        mdl_lo = l;
        mdl_dz = dz;
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        if (scb.size() == 0) begin
            chk({tag, " scoreboard_empty"}, 64'(1), 64'(0));
        end else begin
            e = scb.pop_front();
            chk({tag, " hi"}, 64'(hi), 64'(e.hi));
            chk({tag, " lo"}, 64'(lo), 64'(e.lo));
            chk({tag, " dz"}, 64'(div_by_zero), 64'(e.dz));
        end
    endtask

    // Reference computed with wide native arithmetic, independent of the shift engine.
    function automatic exp_t model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sbv, r;
        logic [63:0]        ua, ub, u;
        exp_t               e;
        sa   = {{32{a[31]}}, a};
        sbv  = {{32{b[31]}}, b};
        ua   = {32'h0, a};
        ub   = {32'h0, b};
        e.hi = mdl_hi;
        e.lo = mdl_lo;
        e.dz = 1'b0;
        if (o == OP_MULT) begin
            r = sa * sbv;
            e.hi = r[63:32];
            e.lo = r[31:0];
        end else if (o == OP_MULTU) begin
            u = ua * ub;
            e.hi = u[63:32];
            e.lo = u[31:0];
        end else if (b == 32'h0) begin
            e.hi = a;
            e.lo = 32'hFFFFFFFF;
            e.dz = 1'b1;
        end else if (o == OP_DIV) begin
            r = sa / sbv;
            e.lo = r[31:0];
            r = sa % sbv;
            e.hi = r[31:0];
        end else begin
            u = ua / ub;
            e.lo = u[31:0];
            u = ua % ub;
            e.hi = u[31:0];
        end
        return e;
    endfunction

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int inject);
        logic [31:0] h0, l0;
        int          n;
        logic        held;
        h0    = hi;
        l0    = lo;
        op    = o;
        x     = a;
        y     = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n     = 0;
        held  = 1'b1;
        while (busy && n < 100) begin
            n++;
            if (hi !== h0 || lo !== l0 || done !== 1'b0) held = 1'b0;
            if (n == inject) begin
                start = 1'b1;
                op    = OP_DIVU;
                x     = 32'd9;
                y     = 32'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk({tag, " busy_cycles"}, 64'(n), 64'(33));
        chk({tag, " hilo_held"}, 64'(held), 64'(1));
        chk({tag, " done"}, 64'(done), 64'(1));
        pop_cmp(tag);
        @(posedge clk); #1;
        chk({tag, " done_drop"}, 64'(done), 64'(0));
    endtask

    initial begin
        exp_t        e;
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        rst   = 1'b1;
        start = 1'b0;
        op    = 3'd0;
        x     = '0;
        y     = '0;
        mdl_hi = '0;
        mdl_lo = '0;
        mdl_dz = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset hi", 64'(hi), 64'(0));
        chk("reset lo", 64'(lo), 64'(0));
        chk("reset busy", 64'(busy), 64'(0));
        chk("reset done", 64'(done), 64'(0));
        chk("reset dz", 64'(div_by_zero), 64'(0));

        push_exp(32'hFFFFFFFE, 32'h00000001, 1'b0);
        run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);

        push_exp(32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
        run_op("mult_neg", OP_MULT, 32'hFFFFFFFD, 32'd7, 0);

        push_exp(32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run_op("div_neg", OP_DIV, 32'hFFFFFFF9, 32'd2, 0);

        push_exp(32'd100, 32'hFFFFFFFF, 1'b1);
        run_op("divu_zero", OP_DIVU, 32'd100, 32'd0, 0);

        push_exp(32'd2, 32'd14, 1'b0);
        run_op("divu_7", OP_DIVU, 32'd100, 32'd7, 0);

        push_exp(32'hDEADBEEF, mdl_lo, mdl_dz);
        push_exp(32'hDEADBEEF, 32'h12345678, mdl_dz);
        op    = OP_MTHI;
        x     = 32'hDEADBEEF;
        start = 1'b1;
        @(posedge clk); #1;
        chk("mthi done", 64'(done), 64'(1));
        chk("mthi busy", 64'(busy), 64'(0));
        pop_cmp("mthi");
        op = OP_MTLO;
        x  = 32'h12345678;
        @(posedge clk); #1;
        start = 1'b0;
        chk("mtlo done", 64'(done), 64'(1));
        chk("mtlo busy", 64'(busy), 64'(0));
        pop_cmp("mtlo");

        op    = 3'd6;
        x     = 32'hCAFEF00D;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("undef done", 64'(done), 64'(0));
        chk("undef busy", 64'(busy), 64'(0));
        chk("undef hi", 64'(hi), 64'(mdl_hi));
        chk("undef lo", 64'(lo), 64'(mdl_lo));

        push_exp(32'd0, 32'd30, 1'b0);
        run_op("multu_inject", OP_MULTU, 32'd5, 32'd6, 10);

        push_exp(32'd0, 32'h80000000, 1'b0);
        run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 0);

        op    = OP_DIV;
        x     = 32'd1000;
        y     = 32'd3;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) begin
            @(posedge clk); #1;
        end
        chk("abort busy_before", 64'(busy), 64'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mdl_hi = '0;
        mdl_lo = '0;
        mdl_dz = 1'b0;
        chk("abort busy", 64'(busy), 64'(0));
        chk("abort done", 64'(done), 64'(0));
        chk("abort hi", 64'(hi), 64'(0));
        chk("abort lo", 64'(lo), 64'(0));

        push_exp(32'd0, 32'd6, 1'b0);
        run_op("multu_after_rst", OP_MULTU, 32'd2, 32'd3, 0);

        for (int i = 0; i < 8; i++) begin
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i == 3) ? 32'h0 : $urandom;
            if (i == 5) rb = rb >> 20;
            e = model(ro, ra, rb);
            push_exp(e.hi, e.lo, e.dz);
            run_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
